blackjack_multi: RTL and testbench

Parametrised successor of the single-player blackjack game controller: a Moore FSM that sequences shuffle, initial deal, player turns, dealer turn and result for `NUM_PLAYERS` seats against one dealer. It drives card-request strobes with a req/ack handshake toward the card-fetch/memory block and consumes per-seat point totals from the scoring block. It also adds seat indexing, replay without reset, dealer skip when every seat busts, and a configurable animation hold.

---
 rtl/blackjack_multi.sv | 258 +++++++++++++++++++++++++
 tb/tb_blackjack_multi.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/blackjack_multi.sv
// Multi-seat blackjack game controller: Moore FSM sequencing shuffle, deal, player turns, dealer turn and result.
// Optional macro BJ_ANIM_HOLD_EN enables the TIMER_CYCLES animation hold; otherwise animation states last one cycle.
module blackjack_multi #(
    parameter int NUM_PLAYERS  = 2,
    parameter int PTS_W        = 6,
    parameter int DEALER_STAND = 17,
    parameter int TIMER_CYCLES = 100000000,
    localparam int IDX_W       = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         embaralhar_ok,
    input  logic                         hit,
    input  logic                         stay,
    input  logic                         cartaok,
    input  logic                         novo_jogo,
    input  logic [NUM_PLAYERS*PTS_W-1:0] pts_jogador,
    input  logic [PTS_W-1:0]             pts_dealer,
    output logic                         pjogador,
    output logic                         pdealer,
    output logic [IDX_W-1:0]             jogador_idx,
    output logic                         player_hit,
    output logic                         player_stay,
    output logic                         dealer_hit,
    output logic                         dealer_stay,
    output logic [NUM_PLAYERS-1:0]       win,
    output logic [NUM_PLAYERS-1:0]       lose,
    output logic [NUM_PLAYERS-1:0]       tie,
    output logic                         fim
);
    localparam int CNT_W = $clog2(NUM_PLAYERS + 1);
    localparam logic [CNT_W-1:0] DEALER_SLOT = CNT_W'(NUM_PLAYERS);
    localparam logic [CNT_W-1:0] LAST_SEAT   = CNT_W'(NUM_PLAYERS - 1);
    localparam logic [PTS_W-1:0] PTS_21      = PTS_W'(21);
    localparam logic [PTS_W-1:0] PTS_STAND   = PTS_W'(DEALER_STAND);

    typedef enum logic [4:0] {
        INICIO      = 5'd0,
        EMBARALHAR  = 5'd1,
        DEAL_REQ    = 5'd2,
        DEAL_WAIT   = 5'd3,
        VEZ_JOGADOR = 5'd4,
        HIT_JOG     = 5'd5,
        FETCH_JOG   = 5'd6,
        WAIT_JOG    = 5'd7,
        STAY_JOG    = 5'd8,
        PROX_JOG    = 5'd9,
        VEZ_DEALER  = 5'd10,
        HIT_DEALER  = 5'd11,
        FETCH_DEAL  = 5'd12,
        WAIT_DEAL   = 5'd13,
        STAY_DEALER = 5'd14,
        FIM_JOGO    = 5'd15
    } state_t;

    state_t           state_r, state_n;
    logic [CNT_W-1:0] idx_r, idx_n;
    logic             rnd_r, rnd_n;
    logic             vivos_r, vivos_n;
    logic             hold_done_s;
    logic [PTS_W-1:0] seat_pts_s;
    logic [PTS_W-1:0] pk_s;

`ifdef BJ_ANIM_HOLD_EN
    localparam int TMR_W = $clog2(TIMER_CYCLES + 1);
    logic [TMR_W-1:0] timer_r;

    // Animation timer: restarts on every state change so each hold state sees a fresh count.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            timer_r <= '0;
        end else if (state_n != state_r) begin
            timer_r <= '0;
        end else begin
            timer_r <= timer_r + TMR_W'(1);
        end
    end

    assign hold_done_s = (timer_r == TMR_W'(TIMER_CYCLES - 1));
`else
    // One-cycle animation states for fast simulation.
    assign hold_done_s = (TIMER_CYCLES >= 1);
`endif

    // Select the active seat's total.
    always_comb begin
        seat_pts_s = '0;
        for (int k = 0; k < NUM_PLAYERS; k++) begin
            if (idx_r == CNT_W'(k)) begin
                seat_pts_s = pts_jogador[k*PTS_W +: PTS_W];
            end else begin
                seat_pts_s = seat_pts_s;
            end
        end
    end

    // State, seat counter, round bit and survivor flag.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= INICIO;
            idx_r   <= '0;
            rnd_r   <= 1'b0;
            vivos_r <= 1'b0;
        end else begin
            state_r <= state_n;
            idx_r   <= idx_n;
            rnd_r   <= rnd_n;
            vivos_r <= vivos_n;
        end
    end

    // Next-state logic and Moore output decode.
    always_comb begin
        state_n     = state_r;
        idx_n       = idx_r;
        rnd_n       = rnd_r;
        vivos_n     = vivos_r;
        pjogador    = 1'b0;
        pdealer     = 1'b0;
        jogador_idx = '0;
        player_hit  = 1'b0;
        player_stay = 1'b0;
        dealer_hit  = 1'b0;
        dealer_stay = 1'b0;
        win         = '0;
        lose        = '0;
        tie         = '0;
        fim         = 1'b0;
        pk_s        = '0;

        case (state_r)
            INICIO: begin
                state_n = EMBARALHAR;
                idx_n   = '0;
                rnd_n   = 1'b0;
                vivos_n = 1'b0;
            end
            EMBARALHAR: begin
                if (embaralhar_ok) state_n = DEAL_REQ;
                else               state_n = EMBARALHAR;
            end
            DEAL_REQ: begin
                if (idx_r < DEALER_SLOT) begin
                    pjogador    = 1'b1;
                    jogador_idx = idx_r[IDX_W-1:0];
                end else begin
                    pdealer = 1'b1;
                end
                if (cartaok) state_n = DEAL_WAIT;
                else         state_n = DEAL_REQ;
            end
            DEAL_WAIT: begin
                if (!cartaok) begin
                    if (idx_r == DEALER_SLOT) begin
                        idx_n   = '0;
                        rnd_n   = !rnd_r;
                        state_n = rnd_r ? VEZ_JOGADOR : DEAL_REQ;
                    end else begin
                        idx_n   = idx_r + CNT_W'(1);
                        state_n = DEAL_REQ;
                    end
                end else begin
                    state_n = DEAL_WAIT;
                end
            end
            VEZ_JOGADOR: begin
                jogador_idx = idx_r[IDX_W-1:0];
                if (seat_pts_s > PTS_21) begin
                    state_n = PROX_JOG;
                end else if (seat_pts_s == PTS_21) begin
                    state_n = PROX_JOG;
                    vivos_n = 1'b1;
                end else if (hit) begin
                    state_n = HIT_JOG;
                end else if (stay) begin
                    state_n = STAY_JOG;
                end else begin
                    state_n = VEZ_JOGADOR;
                end
            end
            HIT_JOG: begin
                jogador_idx = idx_r[IDX_W-1:0];
                player_hit  = 1'b1;
                if (hold_done_s) state_n = FETCH_JOG;
                else             state_n = HIT_JOG;
            end
            FETCH_JOG: begin
                jogador_idx = idx_r[IDX_W-1:0];
                pjogador    = 1'b1;
                if (cartaok) state_n = WAIT_JOG;
                else         state_n = FETCH_JOG;
            end
            WAIT_JOG: begin
                jogador_idx = idx_r[IDX_W-1:0];
                if (!cartaok) state_n = VEZ_JOGADOR;
                else          state_n = WAIT_JOG;
            end
            STAY_JOG: begin
                jogador_idx = idx_r[IDX_W-1:0];
                player_stay = 1'b1;
                vivos_n     = 1'b1;
                if (hold_done_s) state_n = PROX_JOG;
                else             state_n = STAY_JOG;
            end
            PROX_JOG: begin
                jogador_idx = idx_r[IDX_W-1:0];
                if (idx_r < LAST_SEAT) begin
                    idx_n   = idx_r + CNT_W'(1);
                    state_n = VEZ_JOGADOR;
                end else if (vivos_r) begin
                    state_n = VEZ_DEALER;
                end else begin
                    state_n = FIM_JOGO;
                end
            end
            VEZ_DEALER: begin
                if (pts_dealer > PTS_21)           state_n = FIM_JOGO;
                else if (pts_dealer >= PTS_STAND)  state_n = STAY_DEALER;
                else                               state_n = HIT_DEALER;
            end
            HIT_DEALER: begin
                dealer_hit = 1'b1;
                if (hold_done_s) state_n = FETCH_DEAL;
                else             state_n = HIT_DEALER;
            end
            FETCH_DEAL: begin
                pdealer = 1'b1;
                if (cartaok) state_n = WAIT_DEAL;
                else         state_n = FETCH_DEAL;
            end
            WAIT_DEAL: begin
                if (!cartaok) state_n = VEZ_DEALER;
                else          state_n = WAIT_DEAL;
            end
            STAY_DEALER: begin
                dealer_stay = 1'b1;
                if (hold_done_s) state_n = FIM_JOGO;
                else             state_n = STAY_DEALER;
            end
            FIM_JOGO: begin
                fim = 1'b1;
                for (int k = 0; k < NUM_PLAYERS; k++) begin
                    pk_s = pts_jogador[k*PTS_W +: PTS_W];
                    if (pk_s > PTS_21)           lose[k] = 1'b1;
                    else if (pts_dealer > PTS_21) win[k]  = 1'b1;
                    else if (pk_s > pts_dealer)  win[k]  = 1'b1;
                    else if (pk_s < pts_dealer)  lose[k] = 1'b1;
                    else                         tie[k]  = 1'b1;
                end
                if (novo_jogo) state_n = INICIO;
                else           state_n = FIM_JOGO;
            end
            default: begin
                state_n = INICIO;
            end
        endcase
    end
endmodule

// File: tb/tb_blackjack_multi.sv
// Self-checking bench for blackjack_multi: result-decode vector table plus directed game sequences.
module tb_blackjack_multi;
    localparam int NP = 2;
    localparam int PW = 6;
    localparam int TC = 4;
`ifdef BJ_ANIM_HOLD_EN
    localparam int HOLD = TC;
`else
    localparam int HOLD = 1;
`endif

    logic            clock;
    logic            reset;
    logic            embaralhar_ok, hit, stay, cartaok, novo_jogo;
    logic [NP*PW-1:0] pts_jogador;
    logic [PW-1:0]   pts_dealer;
    logic            pjogador, pdealer;
    logic [0:0]      jogador_idx;
    logic            player_hit, player_stay, dealer_hit, dealer_stay;
    logic [NP-1:0]   win, lose, tie;
    logic            fim;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [PW-1:0] p0, p1, pd;
        logic [1:0]    w, l, t;
    } vec_t;
    vec_t tbl [8];

    blackjack_multi #(.NUM_PLAYERS(NP), .PTS_W(PW), .DEALER_STAND(17), .TIMER_CYCLES(TC)) dut (
        .clock(clock), .reset(reset), .embaralhar_ok(embaralhar_ok), .hit(hit), .stay(stay),
        .cartaok(cartaok), .novo_jogo(novo_jogo), .pts_jogador(pts_jogador), .pts_dealer(pts_dealer),
        .pjogador(pjogador), .pdealer(pdealer), .jogador_idx(jogador_idx),
        .player_hit(player_hit), .player_stay(player_stay), .dealer_hit(dealer_hit),
        .dealer_stay(dealer_stay), .win(win), .lose(lose), .tie(tie), .fim(fim)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0:       return pjogador;
            1:       return pdealer;
            2:       return player_hit;
            3:       return player_stay;
            4:       return dealer_hit;
            5:       return dealer_stay;
            default: return fim;
        endcase
    endfunction

    function automatic logic [13:0] all_outs();
        return {pjogador, pdealer, jogador_idx, player_hit, player_stay,
                dealer_hit, dealer_stay, win, lose, tie, fim};
    endfunction

    task automatic wait_for(input int sel, input string name);
        int n = 0;
        while (!sig(sel) && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) chk({name, " timeout"}, 32'd0, 32'd1);
    endtask

    task automatic count_hold(input int sel, input string name);
        int n = 0;
        while (sig(sel) && n < 100) begin
            n++;
            tick();
        end
        chk(name, n, HOLD);
    endtask

    task automatic serve_card(input logic dealer, input logic [0:0] idx, input string name);
        int n = 0;
        while (!(pjogador | pdealer) && n < 50) begin
            tick();
            n++;
        end
        chk({name, " req"}, {30'd0, pjogador, pdealer}, dealer ? 32'd1 : 32'd2);
        if (!dealer) chk({name, " idx"}, {31'd0, jogador_idx}, {31'd0, idx});
        tick();
        chk({name, " req held"}, {31'd0, pjogador | pdealer}, 32'd1);
        cartaok = 1'b1;
        tick();
        chk({name, " req drop"}, {31'd0, pjogador | pdealer}, 32'd0);
        cartaok = 1'b0;
    endtask

    task automatic shuffle_and_deal(input string tag);
        embaralhar_ok = 1'b1;
        tick();
        embaralhar_ok = 1'b0;
        serve_card(1'b0, 1'b0, {tag, " d1s0"});
        serve_card(1'b0, 1'b1, {tag, " d1s1"});
        serve_card(1'b1, 1'b0, {tag, " d1dl"});
        serve_card(1'b0, 1'b0, {tag, " d2s0"});
        serve_card(1'b0, 1'b1, {tag, " d2s1"});
        serve_card(1'b1, 1'b0, {tag, " d2dl"});
        tick();
    endtask

    initial begin
        logic seen_dealer;
        tbl[0] = '{p0: 6'd20, p1: 6'd18, pd: 6'd19, w: 2'b01, l: 2'b10, t: 2'b00};
        tbl[1] = '{p0: 6'd22, p1: 6'd23, pd: 6'd16, w: 2'b00, l: 2'b11, t: 2'b00};
        tbl[2] = '{p0: 6'd21, p1: 6'd17, pd: 6'd22, w: 2'b11, l: 2'b00, t: 2'b00};
        tbl[3] = '{p0: 6'd19, p1: 6'd19, pd: 6'd19, w: 2'b00, l: 2'b00, t: 2'b11};
        tbl[4] = '{p0: 6'd22, p1: 6'd21, pd: 6'd21, w: 2'b00, l: 2'b01, t: 2'b10};
        tbl[5] = '{p0: 6'd0,  p1: 6'd63, pd: 6'd0,  w: 2'b00, l: 2'b10, t: 2'b01};
        tbl[6] = '{p0: 6'd21, p1: 6'd20, pd: 6'd25, w: 2'b11, l: 2'b00, t: 2'b00};
        tbl[7] = '{p0: 6'd16, p1: 6'd21, pd: 6'd17, w: 2'b10, l: 2'b01, t: 2'b00};

        reset = 1'b0; embaralhar_ok = 1'b0; hit = 1'b0; stay = 1'b0;
        cartaok = 1'b0; novo_jogo = 1'b0;
        pts_jogador = {6'd10, 6'd12};
        pts_dealer  = 6'd10;

        // Reset and shuffle wait
        repeat (3) tick();
        chk("reset outs", {18'd0, all_outs()}, 32'd0);
        reset = 1'b1;
        tick();
        chk("embaralhar outs", {18'd0, all_outs()}, 32'd0);
        tick();
        chk("embaralhar waits", {31'd0, pjogador}, 32'd0);
        embaralhar_ok = 1'b1;
        tick();
        embaralhar_ok = 1'b0;
        chk("first req", {30'd0, pjogador, jogador_idx}, 32'd2);
        serve_card(1'b0, 1'b0, "g1 d1s0");
        serve_card(1'b0, 1'b1, "g1 d1s1");
        serve_card(1'b1, 1'b0, "g1 d1dl");
        serve_card(1'b0, 1'b0, "g1 d2s0");
        serve_card(1'b0, 1'b1, "g1 d2s1");
        serve_card(1'b1, 1'b0, "g1 d2dl");
        tick();
        tick();
        chk("turn idle", {28'd0, pjogador, pdealer, player_hit, player_stay}, 32'd0);
        chk("turn seat0", {31'd0, jogador_idx}, 32'd0);

        // Game 1: both seats bust, dealer skipped
        hit = 1'b1;
        tick();
        hit = 1'b0;
        count_hold(2, "s0 hit hold");
        chk("s0 fetch", {30'd0, pjogador, jogador_idx}, 32'd2);
        pts_jogador[5:0] = 6'd22;
        serve_card(1'b0, 1'b0, "s0 hit card");
        hit = 1'b1;
        stay = 1'b1;
        wait_for(2, "s1 hit+stay");
        chk("hit priority", {31'd0, player_stay}, 32'd0);
        chk("s1 idx", {31'd0, jogador_idx}, 32'd1);
        hit = 1'b0;
        stay = 1'b0;
        count_hold(2, "s1 hit hold");
        chk("s1 fetch", {30'd0, pjogador, jogador_idx}, 32'd3);
        pts_jogador[11:6] = 6'd23;
        serve_card(1'b0, 1'b1, "s1 hit card");
        seen_dealer = 1'b0;
        for (int n = 0; n < 50; n++) begin
            if (fim) break;
            if (dealer_hit | dealer_stay) seen_dealer = 1'b1;
            tick();
        end
        chk("bust fim", {31'd0, fim}, 32'd1);
        chk("bust no dealer", {31'd0, seen_dealer}, 32'd0);
        chk("bust lose", {30'd0, lose}, 32'd3);
        chk("bust win/tie", {28'd0, win, tie}, 32'd0);

        // Replay without reset
        novo_jogo = 1'b1;
        tick();
        novo_jogo = 1'b0;
        chk("replay inicio outs", {18'd0, all_outs()}, 32'd0);
        tick();
        chk("replay embaralhar outs", {18'd0, all_outs()}, 32'd0);

        // Game 2: both stay, dealer hits once then stands
        pts_jogador = {6'd18, 6'd20};
        pts_dealer  = 6'd16;
        shuffle_and_deal("g2");
        stay = 1'b1;
        tick();
        stay = 1'b0;
        count_hold(3, "s0 stay hold");
        stay = 1'b1;
        wait_for(3, "s1 stay");
        chk("s1 stay idx", {31'd0, jogador_idx}, 32'd1);
        stay = 1'b0;
        count_hold(3, "s1 stay hold");
        wait_for(4, "dealer hit");
        count_hold(4, "dealer hit hold");
        chk("dealer fetch", {30'd0, pjogador, pdealer}, 32'd1);
        pts_dealer = 6'd19;
        serve_card(1'b1, 1'b0, "dealer card");
        wait_for(5, "dealer stay");
        chk("dealer stay not hit", {31'd0, dealer_hit}, 32'd0);
        count_hold(5, "dealer stay hold");
        chk("g2 fim", {31'd0, fim}, 32'd1);
        chk("g2 results", {26'd0, win, lose, tie}, {26'd0, 2'b01, 2'b10, 2'b00});

        // Result decode table in FIM_JOGO
        for (int i = 0; i < 8; i++) begin
            pts_jogador = {tbl[i].p1, tbl[i].p0};
            pts_dealer  = tbl[i].pd;
            #1;
            chk($sformatf("vec%0d results", i), {26'd0, win, lose, tie},
                {26'd0, tbl[i].w, tbl[i].l, tbl[i].t});
        end

        // Reset asserted mid-handshake
        tick();
        novo_jogo = 1'b1;
        tick();
        novo_jogo = 1'b0;
        tick();
        embaralhar_ok = 1'b1;
        tick();
        embaralhar_ok = 1'b0;
        chk("pre-reset req", {31'd0, pjogador}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("async reset outs", {18'd0, all_outs()}, 32'd0);
        tick();
        reset = 1'b1;
        tick();
        chk("post-reset outs", {18'd0, all_outs()}, 32'd0);
        embaralhar_ok = 1'b1;
        tick();
        embaralhar_ok = 1'b0;
        chk("post-reset req", {30'd0, pjogador, jogador_idx}, 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
